// File: rtl/cpu_trace_ctl_if.sv
// Read-out stream of the trace controller: valid/ready handshake carrying
// one captured pipeline entry per transfer, plus an end-of-dump marker.
interface cpu_trace_ctl_if;
  logic        rd_valid;
  logic        rd_ready;
  logic [34:0] rd_data;   // {stall_2a, kill_4a, st__push_5a, pc_4a}
  logic        rd_last;

  // Trace controller side: produces the stream.
  modport master (
    output rd_valid,
    output rd_data,
    output rd_last,
    input  rd_ready
  );

  // Debug consumer side: accepts the stream.
  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_last,
    output rd_ready
  );
endinterface

// File: rtl/cpu_trace_ctl.sv
// Trace-capture controller for the 5-stage CPU pipeline. Once armed it
// records stage-4 state every cycle into a circular buffer, stops after a
// PC-match trigger plus a post-trigger count, and streams the retained
// entries out oldest-first. Pure observer: nothing feeds back into the core.
module cpu_trace_ctl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_4a,
  input  logic                  kill_4a,
  input  logic                  stall_2a,
  input  logic                  st__push_5a,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig_en,
  input  logic [31:0]           trig_pc,
  input  logic [DEPTH_LOG2-1:0] post_cnt,
  cpu_trace_ctl_if.master       rd,
  output logic [1:0]            state,
  output logic                  triggered,
  output logic                  done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Occupancy value meaning "buffer completely full".
  localparam logic [DEPTH_LOG2:0] FILL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DUMP  = 2'd3
  } state_t;

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_post_left;
  logic [DEPTH_LOG2:0]   r_fill;       // entries held, saturates at DEPTH
  logic [DEPTH_LOG2:0]   r_remaining;  // entries still to stream out
  logic                  r_triggered;
  logic                  r_done;
  logic                  r_rd_valid;
  logic                  r_rd_last;
  logic [34:0]           r_buf [DEPTH];

  logic                  w_capture;
  logic [34:0]           w_entry;
  logic                  w_trigger;
  logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
  logic [DEPTH_LOG2:0]   w_fill_nxt;
  logic [DEPTH_LOG2-1:0] w_dump_rd_ptr;
  logic                  w_dump_last;
  logic                  w_handshake;

  assign w_capture    = (r_state == S_ARMED) || (r_state == S_POST);
  assign w_entry      = {stall_2a, kill_4a, st__push_5a, pc_4a};
  assign w_trigger    = trig_en && (pc_4a == trig_pc) && !kill_4a;
  assign w_wr_ptr_nxt = r_wr_ptr + 1'b1;
  assign w_fill_nxt   = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
  // The capture in the cycle that enters DUMP is part of the dump, so the
  // read start and count are derived from the post-capture pointer/fill.
  assign w_dump_rd_ptr = (w_fill_nxt == FILL_FULL) ? w_wr_ptr_nxt : '0;
  assign w_dump_last   = (w_fill_nxt == (DEPTH_LOG2 + 1)'(1));
  assign w_handshake   = r_rd_valid && rd.rd_ready;

  // Trace memory: one entry written per capturing cycle.
  // NOTE: the buffer is deliberately not reset; fill/rd_ptr decide which
  // entries are ever read, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf[r_wr_ptr] <= w_entry;
    end
  end

  // Combinational read straight off the read pointer: no added latency.
  assign rd.rd_data  = r_buf[r_rd_ptr];
  assign rd.rd_valid = r_rd_valid;
  assign rd.rd_last  = r_rd_last;
  assign state       = r_state;
  assign triggered   = r_triggered;
  assign done        = r_done;

  // Control FSM with registered status and stream outputs.
  // NOTE: all state here uses non-blocking assignments so every branch sees
  // the pre-edge values; later assignments in the block override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_post_left <= '0;
      r_remaining <= '0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // abort wins over a simultaneous arm.
          if (arm && !abort) begin
            r_state     <= S_ARMED;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
          end
        end

        S_ARMED: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_fill   <= w_fill_nxt;
            if (w_trigger) begin
              r_triggered <= 1'b1;
              if (post_cnt == '0) begin
                r_state     <= S_DUMP;
                r_rd_ptr    <= w_dump_rd_ptr;
                r_remaining <= w_fill_nxt;
                r_rd_valid  <= 1'b1;
                r_rd_last   <= w_dump_last;
              end else begin
                r_post_left <= post_cnt;
                r_state     <= S_POST;
              end
            end
          end
        end

        S_POST: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_fill      <= w_fill_nxt;
            r_post_left <= r_post_left - 1'b1;
            if (r_post_left == DEPTH_LOG2'(1)) begin
              r_state     <= S_DUMP;
              r_rd_ptr    <= w_dump_rd_ptr;
              r_remaining <= w_fill_nxt;
              r_rd_valid  <= 1'b1;
              r_rd_last   <= w_dump_last;
            end
          end
        end

        S_DUMP: begin
          if (w_handshake) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            r_rd_last   <= (r_remaining == (DEPTH_LOG2 + 1)'(2));
          end
          // A final handshake still completes under abort, but only a clean
          // finish reports done.
          if (abort || (w_handshake && r_rd_last)) begin
            r_state    <= S_IDLE;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            if (!abort) begin
              r_done <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_ctl.sv
// Bench for cpu_trace_ctl: a queue-based reference model of the trace
// buffer, a per-cycle compare process, directed scenarios with literal
// expectations, and a randomized soak.
module tb_cpu_trace_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_4a;
  logic        kill_4a;
  logic        stall_2a;
  logic        st__push_5a;
  logic        arm;
  logic        abort;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic [3:0]  post_cnt;
  logic [1:0]  state;
  logic        triggered;
  logic        done;

  cpu_trace_ctl_if u_if ();

  cpu_trace_ctl #(.DEPTH_LOG2(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_4a       (pc_4a),
    .kill_4a     (kill_4a),
    .stall_2a    (stall_2a),
    .st__push_5a (st__push_5a),
    .arm         (arm),
    .abort       (abort),
    .trig_en     (trig_en),
    .trig_pc     (trig_pc),
    .post_cnt    (post_cnt),
    .rd          (u_if),
    .state       (state),
    .triggered   (triggered),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 capturing before trigger, 2 capturing after trigger, 3 dumping
  int          m_mode = 0;
  int          m_post_left = 0;
  bit          m_trig = 1'b0;
  bit          m_done = 1'b0;
  logic [34:0] cap_q[$];   // last up to 16 captured entries, oldest first
  logic [34:0] dump_q[$];  // entries still to be streamed
  logic [34:0] m_entry;
  logic [34:0] seen_q[$];  // entries accepted by the consumer
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    m_entry = {stall_2a, kill_4a, st__push_5a, pc_4a};
    if (rst) begin
      m_mode = 0;
      m_trig = 1'b0;
      m_done = 1'b0;
      cap_q.delete();
      dump_q.delete();
    end else begin
      case (m_mode)
        0: if (!abort && arm) begin
          m_mode = 1;
          m_trig = 1'b0;
          m_done = 1'b0;
          cap_q.delete();
        end
        1, 2: begin
          if (abort) begin
            m_mode = 0;
          end else begin
            cap_q.push_back(m_entry);
            if (cap_q.size() > 16) void'(cap_q.pop_front());
            if (m_mode == 1) begin
              if (trig_en && pc_4a == trig_pc && !kill_4a) begin
                m_trig = 1'b1;
                if (post_cnt == 0) begin
                  dump_q = cap_q;
                  m_mode = 3;
                end else begin
                  m_post_left = int'(post_cnt);
                  m_mode = 2;
                end
              end
            end else begin
              m_post_left--;
              if (m_post_left == 0) begin
                dump_q = cap_q;
                m_mode = 3;
              end
            end
          end
        end
        default: begin
          if (u_if.rd_ready && dump_q.size() > 0) void'(dump_q.pop_front());
          if (abort) begin
            m_mode = 0;
            dump_q.delete();
          end else if (dump_q.size() == 0) begin
            m_mode = 0;
            m_done = 1'b1;
          end
        end
      endcase
    end
  end

  // Compare process: outputs sampled mid-cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", 64'(state), 64'(m_mode));
      check("triggered", 64'(triggered), 64'(m_trig));
      check("done", 64'(done), 64'(m_done));
      check("rd_valid", 64'(u_if.rd_valid), 64'(m_mode == 3));
      if (m_mode == 3 && dump_q.size() > 0) begin
        check("rd_data", 64'(u_if.rd_data), 64'(dump_q[0]));
        check("rd_last", 64'(u_if.rd_last), 64'(dump_q.size() == 1));
      end
      if (u_if.rd_valid && u_if.rd_ready) seen_q.push_back(u_if.rd_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drain(input string name);
    seen_q.delete();
    u_if.rd_ready = 1'b1;
    for (int i = 0; i < 40 && state == 2'd3; i++) tick();
    u_if.rd_ready = 1'b0;
    check({name, "_drained"}, 64'(state), 64'd0);
  endtask

  logic [34:0] hold;

  initial begin
    rst = 1'b1; pc_4a = '0; kill_4a = 1'b0; stall_2a = 1'b0; st__push_5a = 1'b0;
    arm = 1'b0; abort = 1'b0; trig_en = 1'b0; trig_pc = '0; post_cnt = '0;
    u_if.rd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_valid", 64'(u_if.rd_valid), 64'd0);
    check("rst_last", 64'(u_if.rd_last), 64'd0);

    // Wrap: 20 captures, last 16 (0x10..0x4C) retained.
    trig_en = 1'b1; trig_pc = 32'h40; post_cnt = 4'd3;
    arm_pulse();
    check("wrap_armed", 64'(state), 64'd1);
    for (int i = 0; i < 40 && state != 2'd3; i++) begin
      pc_4a = 32'(i * 4);
      tick();
    end
    check("wrap_dump", 64'(state), 64'd3);
    check("wrap_trig", 64'(triggered), 64'd1);
    drain("wrap");
    check("wrap_count", 64'(seen_q.size()), 64'd16);
    if (seen_q.size() == 16) begin
      check("wrap_first", 64'(seen_q[0][31:0]), 64'h10);
      check("wrap_last_pc", 64'(seen_q[15][31:0]), 64'h4C);
    end
    check("wrap_done", 64'(done), 64'd1);

    // Short fill: trigger on the very first captured cycle.
    trig_pc = 32'h100; post_cnt = 4'd0; pc_4a = 32'h0;
    arm_pulse();
    pc_4a = 32'h100;
    tick();
    check("short_dump", 64'(state), 64'd3);
    check("short_last", 64'(u_if.rd_last), 64'd1);
    check("short_pc", 64'(u_if.rd_data[31:0]), 64'h100);
    drain("short");
    check("short_count", 64'(seen_q.size()), 64'd1);
    check("short_done", 64'(done), 64'd1);

    // Killed match must not trigger; the later clean match does.
    trig_pc = 32'h80; post_cnt = 4'd0;
    arm_pulse();
    pc_4a = 32'h80; kill_4a = 1'b1;
    tick();
    check("kill_armed", 64'(state), 64'd1);
    check("kill_notrig", 64'(triggered), 64'd0);
    kill_4a = 1'b0; pc_4a = 32'h84;
    tick();
    pc_4a = 32'h80;
    tick();
    check("kill_dump", 64'(state), 64'd3);
    drain("kill");
    check("kill_count", 64'(seen_q.size()), 64'd3);
    if (seen_q.size() == 3) begin
      check("kill_first", 64'({seen_q[0][33], seen_q[0][31:0]}), 64'h1_0000_0080);
      check("kill_third", 64'({seen_q[2][33], seen_q[2][31:0]}), 64'h0_0000_0080);
    end

    // Backpressure: hold, then alternate ready.
    trig_pc = 32'h200; post_cnt = 4'd2;
    arm_pulse();
    for (int i = 0; i < 20 && state != 2'd3; i++) begin
      pc_4a = 32'h1F8 + 32'(i * 4);
      stall_2a = i[0];
      st__push_5a = ~i[0];
      tick();
    end
    stall_2a = 1'b0; st__push_5a = 1'b0;
    check("bp_dump", 64'(state), 64'd3);
    hold = u_if.rd_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 64'(u_if.rd_valid), 64'd1);
      check("bp_hold", 64'(u_if.rd_data), 64'(hold));
    end
    seen_q.delete();
    for (int i = 0; i < 40 && state == 2'd3; i++) begin
      u_if.rd_ready = (i % 2 == 0);
      tick();
    end
    u_if.rd_ready = 1'b0;
    check("bp_count", 64'(seen_q.size()), 64'd5);
    if (seen_q.size() == 5) begin
      check("bp_first", 64'(seen_q[0][31:0]), 64'h1F8);
      check("bp_lastpc", 64'(seen_q[4][31:0]), 64'h208);
    end

    // Reset in the middle of a dump, then a clean capture.
    trig_pc = 32'h300; post_cnt = 4'd0;
    arm_pulse();
    pc_4a = 32'h300;
    tick();
    check("rstd_dump", 64'(state), 64'd3);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rstd_state", 64'(state), 64'd0);
    check("rstd_valid", 64'(u_if.rd_valid), 64'd0);
    check("rstd_trig", 64'(triggered), 64'd0);
    check("rstd_done", 64'(done), 64'd0);
    trig_pc = 32'h10; post_cnt = 4'd1;
    arm_pulse();
    pc_4a = 32'h10; tick();
    pc_4a = 32'h14; tick();
    check("rstd_redump", 64'(state), 64'd3);
    drain("rstd");
    check("rstd_count", 64'(seen_q.size()), 64'd2);

    // Abort during POST.
    trig_pc = 32'h20; post_cnt = 4'd5;
    arm_pulse();
    pc_4a = 32'h20; tick();
    check("abort_post", 64'(state), 64'd2);
    pc_4a = 32'h24; tick();
    abort = 1'b1; tick();
    abort = 1'b0;
    check("abort_idle", 64'(state), 64'd0);
    check("abort_trig", 64'(triggered), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_novalid", 64'(u_if.rd_valid), 64'd0);
    end

    // arm and abort together in IDLE.
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check("armabort", 64'(state), 64'd0);

    // Randomized soak against the model.
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 999) == 0);
      arm         = ($urandom_range(0, 9) == 0);
      abort       = ($urandom_range(0, 199) == 0);
      pc_4a       = 32'($urandom_range(0, 7) * 4);
      kill_4a     = ($urandom_range(0, 3) == 0);
      stall_2a    = 1'($urandom_range(0, 1));
      st__push_5a = 1'($urandom_range(0, 1));
      trig_en     = ($urandom_range(0, 7) != 0);
      trig_pc     = 32'($urandom_range(0, 7) * 4);
      post_cnt    = 4'($urandom_range(0, 15));
      u_if.rd_ready = 1'($urandom_range(0, 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
